// File: rtl/pdm_pkg.sv
// Shared constants and helpers for the PDM-to-PCM CIC decimator.
// Holds the CIC width rule and the saturating output shift.
package pdm_pkg;

    localparam logic signed [1:0] PDM_POS = 2'sb01;
    localparam logic signed [1:0] PDM_NEG = 2'sb11;

    function automatic int cic_w(input int r_log2);
        return 2 + 3 * r_log2;
    endfunction

    // Result is wide; callers truncate to out_w, which is lossless after clamping.
    function automatic logic signed [63:0] sat_shl(
        input logic signed [31:0] value,
        input logic        [3:0]  shift,
        input int                 out_w
    );
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v  = $signed({{32{value[31]}}, value}) <<< shift;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/pdm_cic_comb.sv
// One CIC comb stage, differential delay 1, modular arithmetic.
// y is combinational; the delay line advances only when en is high.
module cic_comb
    import pdm_pkg::*;
#(
    parameter int W = 14
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [W-1:0] x,
    output logic signed [W-1:0] y
);

    logic signed [W-1:0] x_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            x_prev <= '0;
        end else if (en) begin
            x_prev <= x;
        end
    end

    assign y = x - x_prev;

endmodule

// File: rtl/pdm_cic_decimator.sv
// Third-order CIC decimator turning a PDM bitstream into signed PCM,
// with programmable gain shift and a one-deep valid/ready output buffer.
module pdm_cic_decimator
    import pdm_pkg::*;
#(
    parameter int R_LOG2 = 4,
    parameter int OUT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pdm_in,
    input  logic                    pdm_valid,
    input  logic [3:0]              shift_by,
    output logic signed [OUT_W-1:0] pcm_out,
    output logic                    pcm_valid,
    input  logic                    pcm_ready,
    output logic                    overrun
);

    localparam int W = cic_w(R_LOG2);

    logic signed [W-1:0] x;
    logic signed [W-1:0] i1, i2, i3;
    logic signed [W-1:0] i1_n, i2_n, i3_n;
    logic [R_LOG2-1:0]   cnt;
    logic                dec_edge;

    logic signed [W-1:0] dec_smp;
    logic                stb_a;
    logic signed [W-1:0] c1, c2, c3;
    logic signed [W-1:0] c_reg;
    logic                stb_b;
    logic signed [OUT_W-1:0] pcm_next;
    logic                xfer;

    always_comb begin
        x    = pdm_in ? W'(PDM_POS) : W'(PDM_NEG);
        i1_n = i1 + x;
        i2_n = i2 + i1_n;
        i3_n = i3 + i2_n;
    end

    assign dec_edge = pdm_valid && (cnt == '1);
    assign xfer     = pcm_valid && pcm_ready;
    assign pcm_next = OUT_W'(sat_shl(32'(c_reg), shift_by, OUT_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            i1  <= '0;
            i2  <= '0;
            i3  <= '0;
            cnt <= '0;
        end else if (pdm_valid) begin
            i1  <= i1_n;
            i2  <= i2_n;
            i3  <= i3_n;
            cnt <= cnt + 1'b1;
        end
    end

    cic_comb #(.W(W)) u_comb1 (
        .clk(clk), .rst(rst), .en(stb_a), .x(dec_smp), .y(c1)
    );
    cic_comb #(.W(W)) u_comb2 (
        .clk(clk), .rst(rst), .en(stb_a), .x(c1), .y(c2)
    );
    cic_comb #(.W(W)) u_comb3 (
        .clk(clk), .rst(rst), .en(stb_a), .x(c2), .y(c3)
    );

    // Two register stages after the decimation edge give the fixed latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_smp   <= '0;
            stb_a     <= 1'b0;
            c_reg     <= '0;
            stb_b     <= 1'b0;
            pcm_out   <= '0;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            stb_a <= dec_edge;
            if (dec_edge) begin
                dec_smp <= i3_n;
            end
            stb_b <= stb_a;
            if (stb_a) begin
                c_reg <= c3;
            end
            if (stb_b) begin
                if (!pcm_valid || xfer) begin
                    pcm_out   <= pcm_next;
                    pcm_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (xfer) begin
                pcm_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Randomized bench for pdm_cic_decimator against a convolution-based
// CIC model plus a transaction-level buffer/overrun model.
module tb_pdm_cic_decimator;

    localparam int R     = 16;
    localparam int HLEN  = 3 * R - 2;
    localparam int OUT_W = 16;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    pdm_in;
    logic                    pdm_valid;
    logic [3:0]              shift_by;
    logic signed [OUT_W-1:0] pcm_out;
    logic                    pcm_valid;
    logic                    pcm_ready;
    logic                    overrun;

    pdm_cic_decimator #(.R_LOG2(4), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .pdm_in(pdm_in), .pdm_valid(pdm_valid),
        .shift_by(shift_by), .pcm_out(pcm_out), .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int t;
        int c;
    } ev_t;

    int  h[HLEN];
    int  xs[$];
    ev_t sched[$];
    int  cyc;
    bit  m_valid;
    int  m_out;
    bit  m_ovr;
    int  last_seen;
    int  n_tests;
    int  n_fail;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int cic_ref();
        int acc = 0;
        int n   = xs.size();
        for (int j = 0; j < HLEN; j++) begin
            if (n - 1 - j >= 0) acc += h[j] * xs[n - 1 - j];
        end
        return acc;
    endfunction

    function automatic int sat_ref(input int c, input int sh);
        longint v = longint'(c) * (longint'(1) << sh);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic model_edge();
        bit xfer;
        if (rst) begin
            xs.delete();
            sched.delete();
            m_valid = 1'b0;
            m_out   = 0;
            m_ovr   = 1'b0;
        end else begin
            xfer = m_valid && pcm_ready;
            if (sched.size() > 0 && sched[0].t == cyc) begin
                if (!m_valid || xfer) begin
                    m_out   = sat_ref(sched[0].c, int'(shift_by));
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
                void'(sched.pop_front());
            end else if (xfer) begin
                m_valid = 1'b0;
            end
            if (pdm_valid) begin
                xs.push_back(pdm_in ? 1 : -1);
                if (xs.size() % R == 0) sched.push_back('{t: cyc + 2, c: cic_ref()});
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("valid", int'(pcm_valid), int'(m_valid));
        if (m_valid) chk("pcm", int'(pcm_out), m_out);
        chk("ovr", int'(overrun), int'(m_ovr));
        if (pcm_valid) last_seen = int'(pcm_out);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_seen = 99999;
    endtask

    // pm: 0 ones, 1 zeros, 2 alternate, 3 random
    // vm: 0 always, 1 every other, 2 random; rm: 0 ready, 1 stall, 2 random
    task automatic run(input int n, input int pm, input int vm, input int rm);
        for (int k = 0; k < n; k++) begin
            case (pm)
                0: pdm_in = 1'b1;
                1: pdm_in = 1'b0;
                2: pdm_in = (k % 2 == 0);
                default: pdm_in = 1'($urandom_range(0, 1));
            endcase
            case (vm)
                0: pdm_valid = 1'b1;
                1: pdm_valid = (k % 2 == 0);
                default: pdm_valid = ($urandom_range(0, 9) < 7);
            endcase
            case (rm)
                0: pcm_ready = 1'b1;
                1: pcm_ready = 1'b0;
                default: pcm_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
        end
    endtask

    initial begin
        int held;
        int lat;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        foreach (h[i]) h[i] = 0;
        for (int a = 0; a < R; a++)
            for (int b = 0; b < R; b++)
                for (int c = 0; c < R; c++)
                    h[a + b + c]++;

        pdm_in    = 1'b0;
        pdm_valid = 1'b0;
        pcm_ready = 1'b1;
        shift_by  = 4'd0;
        do_reset();
        chk("rst_valid", int'(pcm_valid), 0);
        chk("rst_pcm", int'(pcm_out), 0);
        chk("rst_ovr", int'(overrun), 0);

        run(R * 8, 0, 0, 0);
        chk("ones", last_seen, 4096);
        do_reset();
        run(R * 8, 1, 0, 0);
        chk("zeros", last_seen, -4096);
        do_reset();
        run(R * 8, 2, 0, 0);
        chk("alt", last_seen, 0);

        shift_by = 4'd3;
        do_reset();
        run(R * 8, 0, 0, 0);
        chk("ones_sh3", last_seen, 32767);
        do_reset();
        run(R * 8, 1, 0, 0);
        chk("zeros_sh3", last_seen, -32768);
        shift_by = 4'd15;
        do_reset();
        run(R * 8, 0, 0, 0);
        chk("ones_sh15", last_seen, 32767);

        shift_by = 4'd0;
        do_reset();
        run(2 * R * 8, 0, 1, 0);
        chk("gap", last_seen, 4096);

        do_reset();
        run(64, 0, 0, 0);
        run(40, 0, 0, 1);
        held = int'(pcm_out);
        run(4, 0, 0, 1);
        chk("bp_hold", int'(pcm_out), held);
        chk("bp_valid", int'(pcm_valid), 1);
        chk("bp_ovr", int'(overrun), 1);
        run(1, 0, 0, 0);
        chk("bp_ovr_sticky", int'(overrun), 1);

        do_reset();
        for (int k = 0; k < 200; k++) begin
            if (m_valid && (xs.size() % R == 7)) break;
            run(1, 0, 0, 1);
        end
        chk("pre_rst_cnt7", xs.size() % R, 7);
        chk("pre_rst_valid", int'(pcm_valid), 1);
        pdm_valid = 1'b1;
        do_reset();
        chk("mid_rst_valid", int'(pcm_valid), 0);
        chk("mid_rst_pcm", int'(pcm_out), 0);
        chk("mid_rst_ovr", int'(overrun), 0);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            run(1, 0, 0, 0);
            if (pcm_valid) begin
                lat = k;
                break;
            end
        end
        chk("rst_latency", lat, R + 2);

        do_reset();
        for (int b = 0; b < 10; b++) begin
            shift_by = 4'($urandom_range(0, 3));
            run(200, 3, 2, 2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pdm_cic_decimator.md
Name: pdm_cic_decimator

Overview:
- Downstream consumer of the PDM modulator's 1-bit output stream (pdm_output on uio_out[7]).
- Third-order CIC decimator: converts the PDM bitstream back to signed PCM, with a programmable output gain shift.
- Has a one-deep output buffer with a valid/ready handshake.
- Serves as on-chip loopback and self-check for the modulator; also feeds external capture logic.

Parameters:
- R_LOG2, 4, log2 of decimation ratio R (R=16 by default); legal range 1..6.
- OUT_W, 16, PCM output width, signed two's complement.
- Derived, not overridable: W = 2 + 3*R_LOG2, the internal CIC width (14 by default).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pdm_in  in  1  PDM bit.
- pdm_valid  in  1  qualifies pdm_in; one bit is consumed per clk with pdm_valid=1.
- shift_by  in  4  output left-shift, 0..15; sampled when an output is formed.
- pcm_out  out  OUT_W  decimated sample, signed.
- pcm_valid  out  1  pcm_out holds an unconsumed sample.
- pcm_ready  in  1  consumer accepts the sample when pcm_valid && pcm_ready.
- overrun  out  1  sticky: a sample was dropped because the buffer was full.

Behaviour:
- Reset (rst=1 at a clk edge): clears all integrators, combs, the decimation counter (to 0), the output buffer and overrun. After that edge, pcm_out=0, pcm_valid=0 and overrun=0.
- Reset has priority over every other event, including mid-frame or mid-handshake.
- Input mapping: pdm_in=1 maps to +1, pdm_in=0 maps to -1, as a W-bit signed value.
- Integrators:
  - Three cascaded, W bits each, modular wrap-around (no saturation). Wrap is required for CIC correctness.
  - They update only on cycles with pdm_valid=1; otherwise they hold.
- Decimation counter:
  - R_LOG2 bits, increments on pdm_valid and wraps from R-1 to 0.
  - The pdm_valid cycle with counter==R-1 is the "decimation edge".
- Combs:
  - Three cascaded stages, W bits, modular arithmetic, differential delay M=1.
  - They update only on decimation edges, taking as input the integrator-3 value that includes the R-th bit.
  - Each stage computes y = x - x_prev, then stores x_prev <= x.
- Output formation:
  - Comb-3 result c is sign-extended, shifted left by shift_by, and saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - The result is registered into the output buffer.
- Latency: pcm_valid rises exactly 2 clk cycles after the clock edge that samples the decimation-edge pdm_valid.
- Handshake:
  - pcm_out and pcm_valid hold stable while pcm_valid=1 and pcm_ready=0.
  - Transfer occurs on an edge with pcm_valid && pcm_ready. pcm_valid drops the next cycle unless a new sample loads on that same edge; in that case pcm_valid stays 1 with the new value.
- Overrun:
  - If a new sample is formed while the buffer is full and no transfer occurs on that edge, the new sample is discarded and the buffered sample is kept.
  - overrun is set and remains 1 until rst.
- Gaps: pdm_valid may be low for any number of cycles. Filter state freezes and no output is produced.
- Full-scale values (R=16): steady-state all-ones gives c=+4096 and all-zeros gives c=-4096; both fit in W=14.

Decomposition:
- Package pdm_pkg holds:
  - the derived width function W(R_LOG2);
  - a saturating-shift function sat_shl(value, shift, OUT_W);
  - the PDM-to-signed mapping constants (+1/-1).
- One sub-module, cic_comb: a single W-bit comb stage with an enable. It is instantiated three times.
- Integrators stay inline.

Test Plan:
- All ones, pdm_valid=1 continuously, shift_by=0, pcm_ready=1 → every output from the 4th onward is exactly +4096; pcm_valid pulses once per 16 clk.
- All zeros, same setup → outputs settle to exactly -4096. Alternating 1,0 → settled outputs exactly 0.
- All ones with shift_by=3 → settles at +32767 (32768 saturates). All zeros with shift_by=3 → exactly -32768. All ones with shift_by=15 → +32767.
- pdm_valid toggled 1,0 (every other cycle), all ones → one output per 32 clk; settled value +4096; latency is 2 clk after each decimation edge.
- Backpressure: pcm_ready=0 across two decimation edges → first sample held unchanged, second dropped, overrun=1. Raising pcm_ready transfers the held sample; overrun stays 1.
- Assert rst for 1 cycle at counter=7 mid-stream with pcm_valid=1 → next cycle pcm_valid=0, pcm_out=0, overrun=0. With all ones afterwards, the first output appears 16 pdm_valid cycles + 2 clk after reset release.
